// File: rtl/qix_audio_filter.sv
// Qix analog output emulation: one-pole lowpass then DC-blocking highpass,
// time-shared between L and R, decimated and saturated to 16-bit stereo.
module qix_audio_filter #(
    parameter int TICK_DIV  = 208,
    parameter int OUT_DECIM = 2,
    parameter int FRAC      = 8,
    parameter int LPF_SHIFT = 2,
    parameter int DC_SHIFT  = 9
) (
    input  logic        clk_20m,
    input  logic        reset_n,
    input  logic        pause,
    input  logic [15:0] in_l,
    input  logic [15:0] in_r,
    output logic [15:0] out_l,
    output logic [15:0] out_r,
    output logic        out_valid
);

    localparam int W  = 16 + FRAC + 2;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (OUT_DECIM > 1) ? $clog2(OUT_DECIM) : 1;
    localparam logic signed [W-1:0] SAT_MAX = W'(32767);
    localparam logic signed [W-1:0] SAT_MIN = W'(-32768);

    // state   | meaning
    // S_IDLE  | waiting for a tick with pause low
    // S_LPF_L | lowpass update, left
    // S_LPF_R | lowpass update, right
    // S_DC_L  | DC blocker update, left
    // S_DC_R  | DC blocker update, right
    // S_OUT   | decimate and publish saturated samples
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LPF_L = 3'd1,
        S_LPF_R = 3'd2,
        S_DC_L  = 3'd3,
        S_DC_R  = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [TW-1:0] r_tick_cnt;
    logic [DW-1:0] r_dec_cnt;
    logic          w_tick;
    logic          w_capture;
    logic          w_lpf_en;
    logic          w_dc_en;
    logic          w_sel_r;
    logic          w_out_en;
    logic          w_dec_wrap;

    logic signed [15:0]  r_xs_l, r_xs_r;
    logic signed [W-1:0] r_lp_l, r_lp_r;
    logic signed [W-1:0] r_pv_l, r_pv_r;
    logic signed [W-1:0] r_hp_l, r_hp_r;
    logic [15:0]         r_out_l, r_out_r;
    logic                r_out_valid;

    logic signed [15:0]  w_xs;
    logic signed [W-1:0] w_xs_ext;
    logic signed [W-1:0] w_xs_q;
    logic signed [W-1:0] w_lp;
    logic signed [W-1:0] w_pv;
    logic signed [W-1:0] w_hp;
    logic signed [W-1:0] w_lp_diff;
    logic signed [W-1:0] w_lp_new;
    logic signed [W-1:0] w_hp_new;

    function automatic logic [15:0] sat16(input logic signed [W-1:0] v);
        logic signed [W-1:0] s;
        logic [15:0]         res;
        s = v >>> FRAC;
        if (s > SAT_MAX)
            res = 16'h7FFF;
        else if (s < SAT_MIN)
            res = 16'h8000;
        else
            res = 16'(s);
        return res;
    endfunction

    assign w_tick     = (r_tick_cnt == TW'(TICK_DIV - 1));
    assign w_dec_wrap = (r_dec_cnt == DW'(OUT_DECIM - 1));

    always_ff @(posedge clk_20m) begin
        if (!reset_n)
            r_tick_cnt <= '0;
        else if (w_tick)
            r_tick_cnt <= '0;
        else
            r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    always_ff @(posedge clk_20m) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_lpf_en     = 1'b0;
        w_dc_en      = 1'b0;
        w_sel_r      = 1'b0;
        w_out_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_tick && !pause) begin
                    w_capture    = 1'b1;
                    w_state_next = S_LPF_L;
                end
            end
            S_LPF_L: begin
                w_lpf_en     = 1'b1;
                w_state_next = S_LPF_R;
            end
            S_LPF_R: begin
                w_lpf_en     = 1'b1;
                w_sel_r      = 1'b1;
                w_state_next = S_DC_L;
            end
            S_DC_L: begin
                w_dc_en      = 1'b1;
                w_state_next = S_DC_R;
            end
            S_DC_R: begin
                w_dc_en      = 1'b1;
                w_sel_r      = 1'b1;
                w_state_next = S_OUT;
            end
            S_OUT: begin
                w_out_en     = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Single arithmetic path; w_sel_r steers operands and write-back.
    assign w_xs      = w_sel_r ? r_xs_r : r_xs_l;
    assign w_lp      = w_sel_r ? r_lp_r : r_lp_l;
    assign w_pv      = w_sel_r ? r_pv_r : r_pv_l;
    assign w_hp      = w_sel_r ? r_hp_r : r_hp_l;
    assign w_xs_ext  = {{(W-16){w_xs[15]}}, w_xs};
    assign w_xs_q    = w_xs_ext <<< FRAC;
    assign w_lp_diff = w_xs_q - w_lp;
    assign w_lp_new  = w_lp + (w_lp_diff >>> LPF_SHIFT);
    assign w_hp_new  = w_lp - w_pv + w_hp - (w_hp >>> DC_SHIFT);

    always_ff @(posedge clk_20m) begin
        if (!reset_n) begin
            r_xs_l <= '0;
            r_xs_r <= '0;
            r_lp_l <= '0;
            r_lp_r <= '0;
            r_pv_l <= '0;
            r_pv_r <= '0;
            r_hp_l <= '0;
            r_hp_r <= '0;
        end else begin
            if (w_capture) begin
                r_xs_l <= in_l;
                r_xs_r <= in_r;
            end
            if (w_lpf_en) begin
                if (w_sel_r)
                    r_lp_r <= w_lp_new;
                else
                    r_lp_l <= w_lp_new;
            end
            if (w_dc_en) begin
                if (w_sel_r) begin
                    r_hp_r <= w_hp_new;
                    r_pv_r <= w_lp;
                end else begin
                    r_hp_l <= w_hp_new;
                    r_pv_l <= w_lp;
                end
            end
        end
    end

    always_ff @(posedge clk_20m) begin
        if (!reset_n) begin
            r_dec_cnt   <= '0;
            r_out_l     <= '0;
            r_out_r     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_out_en) begin
                if (w_dec_wrap) begin
                    r_dec_cnt   <= '0;
                    r_out_l     <= sat16(r_hp_l);
                    r_out_r     <= sat16(r_hp_r);
                    r_out_valid <= 1'b1;
                end else begin
                    r_dec_cnt <= r_dec_cnt + 1'b1;
                end
            end
        end
    end

    assign out_l     = r_out_l;
    assign out_r     = r_out_r;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_qix_audio_filter.sv
// Bench for qix_audio_filter: tick-level arithmetic reference model with an
// expected-strobe queue, compared every clock.
module tb_qix_audio_filter;

    localparam int TICK_DIV  = 208;
    localparam int OUT_DECIM = 2;
    localparam int FRAC      = 8;
    localparam int LPF_SHIFT = 2;
    localparam int DC_SHIFT  = 9;
    localparam int FIRST_VALID = 2 * TICK_DIV + 5;

    logic        clk_20m = 1'b0;
    logic        reset_n;
    logic        pause;
    logic [15:0] in_l, in_r;
    logic [15:0] out_l, out_r;
    logic        out_valid;

    always #5 clk_20m = ~clk_20m;

    qix_audio_filter #(
        .TICK_DIV (TICK_DIV),
        .OUT_DECIM(OUT_DECIM),
        .FRAC     (FRAC),
        .LPF_SHIFT(LPF_SHIFT),
        .DC_SHIFT (DC_SHIFT)
    ) dut (
        .clk_20m  (clk_20m),
        .reset_n  (reset_n),
        .pause    (pause),
        .in_l     (in_l),
        .in_r     (in_r),
        .out_l    (out_l),
        .out_r    (out_r),
        .out_valid(out_valid)
    );

    typedef struct {
        int          t;
        logic [15:0] l;
        logic [15:0] r;
    } ev_t;

    longint      m_lp [2];
    longint      m_pv [2];
    longint      m_hp [2];
    int          m_dec;
    int          k;
    ev_t         evq[$];
    logic        exp_v;
    logic [15:0] exp_l, exp_r;
    int          checks;
    int          failures;

    function automatic logic [15:0] m_sat(input longint v);
        longint s;
        s = v >>> FRAC;
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        return 16'(s);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_lp[c] = 0;
            m_pv[c] = 0;
            m_hp[c] = 0;
        end
        m_dec = 0;
        evq.delete();
        exp_l = '0;
        exp_r = '0;
    endtask

    // One clock: model the edge, then leave exp_* describing what must be seen.
    task automatic cycle();
        logic rst, p;
        longint x [2];
        rst = reset_n;
        p   = pause;
        x[0] = longint'($signed(in_l));
        x[1] = longint'($signed(in_r));
        @(posedge clk_20m);
        if (!rst) begin
            model_reset();
            k = 0;
        end else begin
            k++;
            if ((k % TICK_DIV) == 0 && !p) begin
                for (int c = 0; c < 2; c++) begin
                    m_lp[c] = m_lp[c] + ((x[c] * (64'sd1 << FRAC) - m_lp[c]) >>> LPF_SHIFT);
                    m_hp[c] = m_lp[c] - m_pv[c] + m_hp[c] - (m_hp[c] >>> DC_SHIFT);
                    m_pv[c] = m_lp[c];
                end
                m_dec = (m_dec + 1) % OUT_DECIM;
                if (m_dec == 0)
                    evq.push_back('{k + 5, m_sat(m_hp[0]), m_sat(m_hp[1])});
            end
        end
        #1;
        exp_v = 1'b0;
        if (evq.size() > 0 && evq[0].t == k) begin
            exp_v = 1'b1;
            exp_l = evq[0].l;
            exp_r = evq[0].r;
            void'(evq.pop_front());
        end
    endtask

    task automatic test_reset();
        int first;
        reset_n = 1'b0;
        in_l = 16'h7FFF;
        in_r = 16'h7FFF;
        repeat (4) begin
            cycle();
            checks++;
            if ({out_valid, out_l, out_r} !== 33'd0) begin
                failures++;
                $display("FAIL reset_hold k=%0d got v=%0b l=%h r=%h exp all 0", k, out_valid, out_l, out_r);
            end
        end
        reset_n = 1'b1;
        first = -1;
        for (int i = 0; i < FIRST_VALID + 20; i++) begin
            cycle();
            checks++;
            if ({out_valid, out_l, out_r} !== {exp_v, exp_l, exp_r}) begin
                failures++;
                $display("FAIL reset_run k=%0d got v=%0b l=%h r=%h exp v=%0b l=%h r=%h",
                         k, out_valid, out_l, out_r, exp_v, exp_l, exp_r);
            end
            if (out_valid && first < 0) first = k;
        end
        checks++;
        if (first !== FIRST_VALID) begin
            failures++;
            $display("FAIL first_valid got %0d exp %0d", first, FIRST_VALID);
        end
    endtask

    task automatic test_cadence();
        int last, pulses;
        logic prev_v;
        last = -1;
        pulses = 0;
        prev_v = 1'b0;
        pause = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            in_l = 16'($urandom);
            in_r = 16'($urandom);
            cycle();
            checks++;
            if ({out_valid, out_l, out_r} !== {exp_v, exp_l, exp_r}) begin
                failures++;
                $display("FAIL cadence_data k=%0d got v=%0b l=%h r=%h exp v=%0b l=%h r=%h",
                         k, out_valid, out_l, out_r, exp_v, exp_l, exp_r);
            end
            if (out_valid) begin
                pulses++;
                if (prev_v) begin
                    failures++;
                    $display("FAIL cadence_width k=%0d got two consecutive strobes exp one", k);
                end
                if (last >= 0) begin
                    checks++;
                    if (k - last != TICK_DIV * OUT_DECIM) begin
                        failures++;
                        $display("FAIL cadence_period got %0d exp %0d", k - last, TICK_DIV * OUT_DECIM);
                    end
                end
                last = k;
            end
            prev_v = out_valid;
        end
        checks++;
        if (pulses < 11) begin
            failures++;
            $display("FAIL cadence_count got %0d exp >= 11", pulses);
        end
    endtask

    task automatic test_dc();
        int samp[$];
        int cyc, peak;
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        in_l = 16'h4000;
        in_r = 16'hC000;
        cyc = 0;
        while (samp.size() < 40 && cyc < 20000) begin
            cycle();
            cyc++;
            checks++;
            if ({out_valid, out_l, out_r} !== {exp_v, exp_l, exp_r}) begin
                failures++;
                $display("FAIL dc_data k=%0d got v=%0b l=%h r=%h exp v=%0b l=%h r=%h",
                         k, out_valid, out_l, out_r, exp_v, exp_l, exp_r);
            end
            if (out_valid) samp.push_back(int'($signed(out_l)));
        end
        checks++;
        if (samp.size() != 40) begin
            failures++;
            $display("FAIL dc_timeout got %0d samples exp 40", samp.size());
        end else begin
            peak = 0;
            foreach (samp[i]) if (samp[i] > peak) peak = samp[i];
            checks++;
            if (peak <= 32'h3000) begin
                failures++;
                $display("FAIL dc_peak got %0d exp > %0d", peak, 32'h3000);
            end
            for (int i = 12; i < 40; i++) begin
                checks++;
                if (samp[i] > samp[i-1] || samp[i] <= 0) begin
                    failures++;
                    $display("FAIL dc_decay idx=%0d got %0d after %0d exp non-increasing positive",
                             i, samp[i], samp[i-1]);
                end
            end
        end
    endtask

    task automatic test_saturation();
        int n, cyc, maxv, after_sat;
        logic seen_sat;
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        in_l = 16'h8000;
        in_r = 16'h0000;
        n = 0;
        cyc = 0;
        while (n < 20 && cyc < 10000) begin
            cycle();
            cyc++;
            checks++;
            if ({out_valid, out_l, out_r} !== {exp_v, exp_l, exp_r}) begin
                failures++;
                $display("FAIL sat_settle k=%0d got v=%0b l=%h r=%h exp v=%0b l=%h r=%h",
                         k, out_valid, out_l, out_r, exp_v, exp_l, exp_r);
            end
            if (out_valid) n++;
        end
        in_l = 16'h7FFF;
        n = 0;
        cyc = 0;
        maxv = -40000;
        seen_sat = 1'b0;
        after_sat = 0;
        while (n < 40 && cyc < 20000) begin
            cycle();
            cyc++;
            checks++;
            if ({out_valid, out_l, out_r} !== {exp_v, exp_l, exp_r}) begin
                failures++;
                $display("FAIL sat_step k=%0d got v=%0b l=%h r=%h exp v=%0b l=%h r=%h",
                         k, out_valid, out_l, out_r, exp_v, exp_l, exp_r);
            end
            if (out_valid) begin
                n++;
                if (int'($signed(out_l)) > maxv) maxv = int'($signed(out_l));
                if (seen_sat) begin
                    after_sat++;
                    checks++;
                    if ($signed(out_l) < 0) begin
                        failures++;
                        $display("FAIL sat_wrap got %0d exp >= 0", $signed(out_l));
                    end
                end
                if (out_l == 16'h7FFF) seen_sat = 1'b1;
            end
        end
        checks++;
        if (maxv != 32767) begin
            failures++;
            $display("FAIL sat_clamp got max %0d exp 32767", maxv);
        end
        checks++;
        if (after_sat == 0 || out_l == 16'h7FFF) begin
            failures++;
            $display("FAIL sat_decay got last %0d exp below 32767", $signed(out_l));
        end
    endtask

    task automatic test_pause();
        int n, cyc, held_l;
        logic [15:0] hl, hr;
        n = 0;
        cyc = 0;
        while (n < 2 && cyc < 2000) begin
            cycle();
            cyc++;
            checks++;
            if ({out_valid, out_l, out_r} !== {exp_v, exp_l, exp_r}) begin
                failures++;
                $display("FAIL pause_pre k=%0d got v=%0b l=%h r=%h exp v=%0b l=%h r=%h",
                         k, out_valid, out_l, out_r, exp_v, exp_l, exp_r);
            end
            if (out_valid) n++;
        end
        hl = exp_l;
        hr = exp_r;
        held_l = int'($signed(hl));
        pause = 1'b1;
        repeat (2000) begin
            in_l = 16'($urandom);
            in_r = 16'($urandom);
            cycle();
            checks++;
            if ({out_valid, out_l, out_r} !== {1'b0, hl, hr}) begin
                failures++;
                $display("FAIL pause_hold k=%0d got v=%0b l=%h r=%h exp v=0 l=%h r=%h",
                         k, out_valid, out_l, out_r, hl, hr);
            end
        end
        pause = 1'b0;
        in_l = 16'h7FFF;
        in_r = 16'h0000;
        n = 0;
        cyc = 0;
        while (n < 1 && cyc < 1000) begin
            cycle();
            cyc++;
            checks++;
            if ({out_valid, out_l, out_r} !== {exp_v, exp_l, exp_r}) begin
                failures++;
                $display("FAIL pause_resume k=%0d got v=%0b l=%h r=%h exp v=%0b l=%h r=%h",
                         k, out_valid, out_l, out_r, exp_v, exp_l, exp_r);
            end
            if (out_valid) n++;
        end
        checks++;
        if (n != 1 || int'($signed(out_l)) > held_l || held_l - int'($signed(out_l)) >= 512) begin
            failures++;
            $display("FAIL pause_continuity got %0d exp within 512 below %0d", $signed(out_l), held_l);
        end
    endtask

    task automatic test_reset_midpass();
        int cyc, first;
        logic hit;
        in_l = 16'h1234;
        in_r = 16'hE000;
        hit = 1'b0;
        cyc = 0;
        while (!hit && cyc < 1200) begin
            cycle();
            cyc++;
            checks++;
            if ({out_valid, out_l, out_r} !== {exp_v, exp_l, exp_r}) begin
                failures++;
                $display("FAIL midpass_pre k=%0d got v=%0b l=%h r=%h exp v=%0b l=%h r=%h",
                         k, out_valid, out_l, out_r, exp_v, exp_l, exp_r);
            end
            if ((k % TICK_DIV) == 0 && evq.size() > 0) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL midpass_timeout got no strobing pass exp one within 1200 clocks");
        end
        cycle();
        reset_n = 1'b0;
        cycle();
        checks++;
        if ({out_valid, out_l, out_r} !== 33'd0) begin
            failures++;
            $display("FAIL midpass_reset got v=%0b l=%h r=%h exp all 0", out_valid, out_l, out_r);
        end
        reset_n = 1'b1;
        first = -1;
        for (int i = 0; i < FIRST_VALID + 10; i++) begin
            cycle();
            checks++;
            if ({out_valid, out_l, out_r} !== {exp_v, exp_l, exp_r}) begin
                failures++;
                $display("FAIL midpass_post k=%0d got v=%0b l=%h r=%h exp v=%0b l=%h r=%h",
                         k, out_valid, out_l, out_r, exp_v, exp_l, exp_r);
            end
            if (out_valid && first < 0) first = k;
        end
        checks++;
        if (first !== FIRST_VALID) begin
            failures++;
            $display("FAIL midpass_first got %0d exp %0d", first, FIRST_VALID);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        pause    = 1'b0;
        in_l     = '0;
        in_r     = '0;
        k        = 0;
        exp_v    = 1'b0;
        model_reset();
        test_reset();
        test_cadence();
        test_dc();
        test_saturation();
        test_pause();
        test_reset_midpass();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
